// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 keyboard-side transmitter.
// Scan-code bytes are queued in an 8-entry FIFO, then sent one at a time as
// 11-bit frames (start, 8 data bits LSB first, odd parity, stop).
// The device drives both ps2_clk and ps2_dat, and both outputs are registered.
// A minimum idle gap is enforced between consecutive frames.
module ps2_kbd_tx #(
    parameter int HALF = 16,
    parameter int GAP  = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_dat,
    output logic       busy,
    output logic [3:0] level
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [7:0] HALF_M1 = 8'(HALF - 1);
    localparam logic [7:0] GAP_V   = 8'(GAP);

    logic [7:0]  fifo_mem [8];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [3:0]  count;
    logic        push;
    logic        pop;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  timer;
    logic [7:0]  timer_nxt;
    logic [3:0]  bit_idx;
    logic [3:0]  idx_nxt;
    logic [7:0]  gap_cnt;
    logic [7:0]  gap_nxt;
    logic [10:0] frame;
    logic [10:0] frame_nxt;
    logic        clk_q;
    logic        dat_q;
    logic        clk_nxt;
    logic        dat_nxt;
    logic [7:0]  head_byte;

    // Full is the only reason to refuse a byte; a pop in the same cycle does not help.
    assign in_ready  = (count != 4'd8);
    assign push      = in_valid && in_ready;
    assign level     = count;
    assign busy      = (state != IDLE) || (count != 4'd0);
    assign ps2_clk   = clk_q;
    assign ps2_dat   = dat_q;
    assign head_byte = fifo_mem[rd_ptr];

    // FIFO storage needs no reset: the count alone says which entries are meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; a push and pop together leave the count alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // State register for the frame sequencer, plus its registered line outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= 8'd0;
            bit_idx <= 4'd0;
            gap_cnt <= GAP_V;
            frame   <= 11'h7FF;
            clk_q   <= 1'b1;
            dat_q   <= 1'b1;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= idx_nxt;
            gap_cnt <= gap_nxt;
            frame   <= frame_nxt;
            clk_q   <= clk_nxt;
            dat_q   <= dat_nxt;
        end
    end

    // Next-state logic: each half-period lasts HALF cycles, and a frame is 11 HIGH/LOW pairs.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        idx_nxt   = bit_idx;
        gap_nxt   = gap_cnt;
        frame_nxt = frame;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (gap_cnt != GAP_V) begin
                    gap_nxt = gap_cnt + 8'd1;
                end
                if ((count != 4'd0) && (gap_cnt == GAP_V)) begin
                    pop       = 1'b1;
                    frame_nxt = {1'b1, ~^head_byte, head_byte, 1'b0};
                    idx_nxt   = 4'd0;
                    timer_nxt = HALF_M1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (timer == 8'd0) begin
                    timer_nxt = HALF_M1;
                    state_nxt = LOW;
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end
            LOW: begin
                if (timer == 8'd0) begin
                    if (bit_idx < 4'd10) begin
                        idx_nxt   = bit_idx + 4'd1;
                        timer_nxt = HALF_M1;
                        state_nxt = HIGH;
                    end else begin
                        gap_nxt   = 8'd0;
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line outputs: data only changes on entry to HIGH, so it is settled a full half-period before the clock falls.
    always_comb begin
        clk_nxt = (state_nxt != LOW);
        dat_nxt = dat_q;
        if ((state_nxt == HIGH) && (state != HIGH)) begin
            dat_nxt = frame_nxt[idx_nxt];
        end else if (state_nxt == IDLE) begin
            dat_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: directed bench for ps2_kbd_tx with a byte scoreboard.
// Accepted bytes are queued as they are offered.  A line monitor rebuilds each
// frame from ps2_dat at every ps2_clk fall and compares it to the queue head.
module tb_ps2_kbd_tx;

    localparam int HALF = 4;
    localparam int GAP  = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       busy;
    logic [3:0] level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int falls_total = 0;

    logic [7:0]  sbq [$];
    logic [10:0] got_log [$];

    logic        prev_clk = 1'b1;
    logic        prev_dat = 1'b1;
    logic        in_frame = 1'b0;
    logic        have_end = 1'b0;
    int          nbits = 0;
    int          start_cyc = 0;
    int          last_end = 0;
    logic [10:0] cap = 11'd0;

    ps2_kbd_tx #(
        .HALF(HALF),
        .GAP (GAP)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .busy    (busy),
        .level   (level)
    );

    // Free-running system clock.
    always #5 clock = ~clock;

    // Cycle counter used to time frames and idle gaps.
    always @(posedge clock) cyc++;

    // Safety net in case the design stalls the bench entirely.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected frame for a byte: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] make_frame(input logic [7:0] d);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) ones++;
        end
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte for one cycle; accept says whether the FIFO should take it.
    task automatic apply_stimulus(input logic [7:0] b, input logic accept);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        check_output("in_ready", {15'd0, in_ready}, {15'd0, accept});
        if (accept) sbq.push_back(b);
        @(posedge clock);
    endtask

    task automatic release_input();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy || nbits != 0) && n < limit) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check_output("drain_in_time", {15'd0, n < limit}, 16'd1);
    endtask

    // Line monitor: rebuild frames from falling ps2_clk edges and score them.
    always @(negedge clock) begin
        if (reset) begin
            nbits    = 0;
            in_frame = 1'b0;
            have_end = 1'b0;
        end else begin
            if (!in_frame && prev_dat && !ps2_dat) begin
                in_frame  = 1'b1;
                start_cyc = cyc;
            end
            if (prev_clk && !ps2_clk) begin
                falls_total++;
                if (nbits == 0 && have_end)
                    check_output("idle_gap", {15'd0, (cyc - last_end) >= (GAP + 1)}, 16'd1);
                if (nbits < 11) cap[nbits] = ps2_dat;
                nbits++;
            end
            if (!prev_clk && ps2_clk && nbits >= 11) begin
                check_output("frame_falls", 16'(nbits), 16'd11);
                check_output("frame_len", 16'(cyc - start_cyc), 16'(22 * HALF));
                got_log.push_back(cap);
                check_output("sb_nonempty", {15'd0, sbq.size() != 0}, 16'd1);
                if (sbq.size() != 0)
                    check_output("frame_bits", {5'd0, cap}, {5'd0, make_frame(sbq.pop_front())});
                nbits    = 0;
                in_frame = 1'b0;
                last_end = cyc;
                have_end = 1'b1;
            end
        end
        prev_clk = ps2_clk;
        prev_dat = ps2_dat;
    end

    // Directed sequence of scenarios.
    initial begin
        int base;
        int n;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("rst_ps2_clk", {15'd0, ps2_clk}, 16'd1);
        check_output("rst_ps2_dat", {15'd0, ps2_dat}, 16'd1);
        check_output("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check_output("rst_busy", {15'd0, busy}, 16'd0);
        check_output("rst_level", {12'd0, level}, 16'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] single byte 0x1C");
        apply_stimulus(8'h1C, 1'b1);
        release_input();
        check_output("push_level", {12'd0, level}, 16'd1);
        check_output("push_busy", {15'd0, busy}, 16'd1);
        @(negedge clock);
        check_output("pop_level", {12'd0, level}, 16'd0);
        check_output("start_bit", {15'd0, ps2_dat}, 16'd0);
        check_output("start_clk_high", {15'd0, ps2_clk}, 16'd1);
        wait_drain(500);
        check_output("log_size_1", 16'(got_log.size()), 16'd1);
        if (got_log.size() >= 1)
            check_output("frame_1C_literal", {5'd0, got_log[0]}, {5'd0, 11'b10000111000});

        $display("[TB] back-to-back 0xF0 0x1C");
        repeat (GAP + 4) @(negedge clock);
        apply_stimulus(8'hF0, 1'b1);
        apply_stimulus(8'h1C, 1'b1);
        release_input();
        wait_drain(1000);
        check_output("log_size_3", 16'(got_log.size()), 16'd3);
        if (got_log.size() >= 3) begin
            check_output("parity_F0", {15'd0, got_log[1][9]}, 16'd1);
            check_output("parity_1C", {15'd0, got_log[2][9]}, 16'd0);
        end

        $display("[TB] nine bytes then held full");
        repeat (GAP + 4) @(negedge clock);
        for (int i = 0; i < 9; i++) apply_stimulus(8'h30 + 8'(i), 1'b1);
        for (int i = 0; i < 3; i++) apply_stimulus(8'hAA, 1'b0);
        release_input();
        check_output("full_level", {12'd0, level}, 16'd8);
        check_output("full_in_ready", {15'd0, in_ready}, 16'd0);
        wait_drain(3000);
        check_output("log_size_12", 16'(got_log.size()), 16'd12);

        $display("[TB] random bytes");
        repeat (GAP + 4) @(negedge clock);
        for (int i = 0; i < 5; i++) apply_stimulus(8'($urandom_range(0, 255)), 1'b1);
        release_input();
        wait_drain(2000);
        check_output("log_size_17", 16'(got_log.size()), 16'd17);

        $display("[TB] reset mid-frame");
        repeat (GAP + 4) @(negedge clock);
        apply_stimulus(8'hA5, 1'b1);
        apply_stimulus(8'h3C, 1'b1);
        release_input();
        base = falls_total;
        n = 0;
        while (falls_total < base + 5 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check_output("reach_bit5", {15'd0, n < 1000}, 16'd1);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check_output("async_ps2_clk", {15'd0, ps2_clk}, 16'd1);
        check_output("async_ps2_dat", {15'd0, ps2_dat}, 16'd1);
        check_output("async_level", {12'd0, level}, 16'd0);
        check_output("async_busy", {15'd0, busy}, 16'd0);
        sbq.delete();
        repeat (2) @(negedge clock);
        check_output("inrst_in_ready", {15'd0, in_ready}, 16'd1);
        check_output("inrst_busy", {15'd0, busy}, 16'd0);
        reset = 1'b0;
        base = falls_total;
        repeat (300) @(negedge clock);
        check_output("no_falls_after_rst", 16'(falls_total - base), 16'd0);
        check_output("post_rst_level", {12'd0, level}, 16'd0);
        check_output("post_rst_clk", {15'd0, ps2_clk}, 16'd1);
        check_output("log_size_final", 16'(got_log.size()), 16'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 SHALL have parameter HALF, default 16, meaning clock cycles per PS/2 clock half-period (legal 2..255).
REQ-002 SHALL have parameter GAP, default 32, meaning minimum idle clock cycles between frames (legal 1..255).
REQ-003 SHALL have port clock  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  scan-code byte offered.
REQ-006 SHALL have port in_data  input  8  scan-code byte.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a byte.
REQ-008 SHALL have port ps2_clk  output  1  device-driven PS/2 clock line, idle high.
REQ-009 SHALL have port ps2_dat  output  1  device-driven PS/2 data line, idle high.
REQ-010 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
REQ-011 SHALL have port level  output  4  FIFO occupancy, 0..8.

Function
REQ-012 SHALL buffer bytes in an 8-entry FIFO with 3-bit wrapping read/write pointers and a 4-bit count.
REQ-013 SHALL drive in_ready = (level != 8), with no dependence on a same-cycle pop.
REQ-014 SHALL accept a push when in_valid & in_ready; the byte is visible in level on the next cycle.
REQ-015 SHALL ignore in_valid when full; the byte is dropped and no state changes.
REQ-016 SHALL handle a simultaneous push and pop (non-full) by leaving level unchanged and advancing both pointers.
REQ-017 SHALL serialise each byte as an 11-bit frame: start 0, data[0]..data[7] LSB first, odd parity (data ones + parity = odd), stop 1.
REQ-018 SHALL use a FSM with states IDLE, HIGH, LOW; ps2_clk=1 in IDLE/HIGH, 0 in LOW; both outputs registered.
REQ-019 In IDLE, SHALL drive ps2_dat=1 and count idle cycles, saturating at GAP.
REQ-020 In IDLE, when the FIFO is non-empty and the gap count is GAP, SHALL pop one byte and load the frame.
REQ-021 On that IDLE transition, SHALL set ps2_dat=start bit, bit index=0, half-timer=HALF-1, and move to HIGH.
REQ-022 In HIGH, SHALL decrement the timer; at 0, move to LOW with timer=HALF-1.
REQ-023 In LOW, SHALL decrement the timer; at 0 with index<10, increment index, drive the next bit on ps2_dat, and move to HIGH.
REQ-024 In LOW, at timer 0 with index=10, SHALL move to IDLE with ps2_dat=1 and clear the gap count.
REQ-025 SHALL change ps2_dat only on LOW->HIGH or IDLE->HIGH transitions, so data is stable HALF cycles before each ps2_clk falling edge.
REQ-026 SHALL make each frame last exactly 22*HALF cycles from leaving IDLE to re-entering IDLE.
REQ-027 SHALL drive busy = (state != IDLE) | (level != 0).
REQ-028 SHALL ignore pushes during a frame for the current frame; they queue for later frames.
REQ-029 SHALL hold the gap count at GAP after reset, so the first frame may start immediately.

Reset
REQ-030 On reset assertion, SHALL immediately set ps2_clk=1, ps2_dat=1, state=IDLE, level=0, pointers=0, index=0, timer=0, gap count=GAP.
REQ-031 SHALL abort a frame in flight when reset asserts mid-frame, discarding the remaining bits and all FIFO contents.
REQ-032 SHALL drive in_ready=1 and busy=0 during and after reset.

Verification
REQ-033 Push 0x1C with HALF=4 -> ps2_dat sampled at each ps2_clk fall = 0,0,0,1,1,1,0,0,0,0,1; 11 falls total; frame lasts 88 cycles.
REQ-034 Push 0xF0 then 0x1C back-to-back -> two frames; parity bits 1 then 0; ps2_clk high for at least GAP+1 cycles between frames.
REQ-035 Push 9 bytes in consecutive cycles while the FSM is idle -> first pops immediately; level peaks at 8; no byte dropped (in_ready never low with valid pending beyond capacity).
REQ-036 Hold the FIFO full with in_valid=1 and no pop -> in_ready=0, level stays 8, extra byte absent from the output stream.
REQ-037 Assert reset at bit 5 of a frame -> ps2_clk=ps2_dat=1 the same cycle (asynchronous); level=0; no further falling edges.
REQ-038 Run a stream of random bytes through this block into the existing PS/2 receiver -> the receiver's FIFO returns identical bytes in order.
